// File: rtl/rr_arb16_ctrl_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: sizes, FSM encoding, helpers.
package rr_arb16_ctrl_pkg;

  localparam int unsigned NREQ  = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Binary requester index to one-hot grant vector.
  function automatic logic [NREQ-1:0] idx2oh(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotate-priority encoder: first set request at or above i_ptr, wrapping upward.
module rr_pick16
  import rr_arb16_ctrl_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_any,
  output logic [SEL_W-1:0] o_idx
);

  logic [SEL_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest set bit after i_ptr wins.
  always_comb begin
    o_any  = |i_req;
    o_idx  = '0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + SEL_W'(k);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb16_ctrl.sv
// Round-robin arbiter for one 16:1-muxed shared resource. Holds a grant until done, then rotates.
// Optional forced release after TIMEOUT cycles without done: define ARB_TIMEOUT_EN.
module rr_arb16_ctrl
  import rr_arb16_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NREQ-1:0]  i_req,
  input  logic             i_done,
  output logic [NREQ-1:0]  o_gnt,
  output logic             o_gnt_valid,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_timeout
);

  if (TIMEOUT >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("TIMEOUT must fit in CNT_W bits");
  end

  arb_state_e       r_state, w_state_d;
  logic [NREQ-1:0]  r_gnt, w_gnt_d;
  logic [SEL_W-1:0] r_sel, w_sel_d;
  logic [SEL_W-1:0] r_last, w_last_d;
  logic             r_valid, w_valid_d;

  logic             w_busy;
  logic             w_hit;
  logic             w_release;
  logic             w_new_grant;
  logic [SEL_W-1:0] w_ptr;
  logic             w_any;
  logic [SEL_W-1:0] w_idx;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_release = w_busy & (i_done | w_hit);
  // In BUSY the pointer follows the current owner, since it becomes "last" on release.
  assign w_ptr     = (w_busy ? r_sel : r_last) + SEL_W'(1);

  rr_pick16 u_pick (
    .i_req (i_req),
    .i_ptr (w_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // Next-state for FSM, grant, select and round-robin pointer.
  always_comb begin
    w_state_d   = r_state;
    w_gnt_d     = r_gnt;
    w_sel_d     = r_sel;
    w_last_d    = r_last;
    w_valid_d   = r_valid;
    w_new_grant = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_new_grant = 1'b1;
          w_state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_last_d = r_sel;
          if (w_any) begin
            w_new_grant = 1'b1;
          end else begin
            // sel keeps the last granted index while idle
            w_gnt_d   = '0;
            w_valid_d = 1'b0;
            w_state_d = ST_IDLE;
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (w_new_grant) begin
      w_gnt_d   = idx2oh(w_idx);
      w_sel_d   = w_idx;
      w_valid_d = 1'b1;
    end
  end

  // Registered state and outputs; reset drops any grant immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= SEL_W'(NREQ - 1);
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_sel   <= w_sel_d;
      r_last  <= w_last_d;
      r_valid <= w_valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_timeout;

  assign w_hit = w_busy & (r_cnt == CNT_W'(TIMEOUT));

  // Hold-time counter: cleared on each new grant, counts BUSY cycles without done.
  always_comb begin
    w_cnt_d = r_cnt;
    if (w_new_grant || !w_busy) begin
      w_cnt_d = '0;
    end else if (!i_done) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  // Timeout counter and one-cycle pulse; a real done wins over a coincident timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_timeout <= w_hit & ~i_done;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_hit     = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_valid;
  assign o_sel       = r_sel;

endmodule
